// File: rtl/uart_tx_if.sv
// ============================================================================
// Module   : uart_tx_if
// Purpose  : Byte valid/ready handshake into the UART transmitter FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_if;
    logic [7:0] i_TX_Byte;
    logic       i_TX_Valid;
    logic       o_TX_Ready;

    modport master (output i_TX_Byte, output i_TX_Valid, input  o_TX_Ready);
    modport slave  (input  i_TX_Byte, input  i_TX_Valid, output o_TX_Ready);
endinterface

`default_nettype wire

// File: rtl/uart_transmitter.sv
// ============================================================================
// Module   : uart_transmitter
// Purpose  : FIFO-buffered 8N1 UART transmitter with registered serial output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_transmitter #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  wire logic  i_clock,
    input  wire logic  i_reset_n,
    uart_tx_if.slave   s_tx,
    output logic       o_TX_Serial,
    output logic       o_TX_Active,
    output logic       o_TX_Done
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_PTR_W:0]   c_FULL_CNT = (c_PTR_W+1)'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_LAST_CLK = c_CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } t_state;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    t_state             r_state;
    t_state             w_state_nxt;
    logic [c_CNT_W-1:0] r_clk_cnt;
    logic [c_CNT_W-1:0] w_clk_cnt_nxt;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_serial;
    logic               w_active;
    logic               w_stop_end;
    logic               w_bit_end;
    logic               r_stop_end;

    assign w_full          = (r_count == c_FULL_CNT);
    assign w_empty         = (r_count == '0);
    assign w_push          = s_tx.i_TX_Valid && !w_full;
    assign s_tx.o_TX_Ready = !w_full;
    assign w_bit_end       = (r_clk_cnt == c_LAST_CLK);

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_tx.i_TX_Byte;
        end
    end

    // Pointers are exactly log2(FIFO_DEPTH) bits, so increments wrap by themselves.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_pop         = 1'b0;
        w_serial      = 1'b1;
        w_active      = 1'b0;
        w_stop_end    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = r_mem[r_rd_ptr];
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = S_START;
                end
            end
            S_START: begin
                w_serial = 1'b0;
                w_active = 1'b1;
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = S_DATA;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CNT_W'(1);
                end
            end
            S_DATA: begin
                w_serial = r_shift[r_bit_idx];
                w_active = 1'b1;
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CNT_W'(1);
                end
            end
            S_STOP: begin
                w_active = 1'b1;
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_stop_end    = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Line outputs trail the state by one cycle; Done is delayed one more so it
    // lands in the idle cycle the line actually shows after the stop bit.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_TX_Serial <= 1'b1;
            o_TX_Active <= 1'b0;
            r_stop_end  <= 1'b0;
            o_TX_Done   <= 1'b0;
        end else begin
            o_TX_Serial <= w_serial;
            o_TX_Active <= w_active;
            r_stop_end  <= w_stop_end;
            o_TX_Done   <= r_stop_end;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_transmitter.sv
// ============================================================================
// Module   : tb_uart_transmitter
// Purpose  : Scoreboard bench for uart_transmitter at 4 and 87 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_transmitter;

    localparam int c_CPB   = 4;
    localparam int c_CPB87 = 87;
    localparam int c_PER   = 10;

    logic clk;
    logic rst_n;
    logic ser4, act4, done4;
    logic ser87, act87, done87;

    uart_tx_if tx4 ();
    uart_tx_if tx87 ();

    uart_transmitter #(.CLKS_PER_BIT(c_CPB), .FIFO_DEPTH(4)) u_dut4 (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .s_tx        (tx4),
        .o_TX_Serial (ser4),
        .o_TX_Active (act4),
        .o_TX_Done   (done4)
    );

    uart_transmitter #(.CLKS_PER_BIT(c_CPB87), .FIFO_DEPTH(4)) u_dut87 (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .s_tx        (tx87),
        .o_TX_Serial (ser87),
        .o_TX_Active (act87),
        .o_TX_Done   (done87)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          done_cnt = 0;
    logic [7:0]  sb_q[$];
    int          start_q[$];

    initial clk = 1'b0;
    always #(c_PER/2) clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog sim_time_exceeded got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst_n && done4) begin
            done_cnt = done_cnt + 1;
            checks = checks + 1;
            if (act4 !== 1'b0 || ser4 !== 1'b1) begin
                errors = errors + 1;
                $display("FAIL done_level got active=%b serial=%b required active=0 serial=1", act4, ser4);
            end
        end
    end

    // Monitor: on each falling start edge, pop the expected byte and check every cycle of the frame.
    initial begin : mon
        logic       prev;
        logic [7:0] exp_b;
        logic [9:0] frame;
        bit         ab;
        bit         ok;
        logic       bad_s;
        logic       bad_a;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !ser4) begin
                start_q.push_back(cyc);
                if (sb_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL frame_unexpected got=start_bit required=idle_line");
                    exp_b = 8'h00;
                end else begin
                    exp_b = sb_q.pop_front();
                end
                frame = {1'b1, exp_b, 1'b0};
                ab = 1'b0;
                for (int b = 0; b < 10 && !ab; b++) begin
                    ok = 1'b1;
                    bad_s = 1'b0;
                    bad_a = 1'b1;
                    for (int c = 0; c < c_CPB && !ab; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (!rst_n) ab = 1'b1;
                        else if (ser4 !== frame[b] || act4 !== 1'b1) begin
                            ok = 1'b0;
                            bad_s = ser4;
                            bad_a = act4;
                        end
                    end
                    if (!ab) begin
                        checks = checks + 1;
                        if (!ok) begin
                            errors = errors + 1;
                            $display("FAIL frame_bit%0d byte=%02h got serial=%b active=%b required serial=%b active=1",
                                     b, exp_b, bad_s, bad_a, frame[b]);
                        end
                    end
                end
                if (!ab) begin
                    @(negedge clk);
                    if (rst_n) begin
                        checks = checks + 1;
                        if (ser4 !== 1'b1 || act4 !== 1'b0 || done4 !== 1'b1) begin
                            errors = errors + 1;
                            $display("FAIL idle_after_stop got serial=%b active=%b done=%b required 1 0 1",
                                     ser4, act4, done4);
                        end
                    end
                end
            end
            prev = ser4;
        end
    end

    task automatic send_byte(input logic [7:0] b, output int stall);
        stall = 0;
        @(negedge clk);
        tx4.i_TX_Byte  = b;
        tx4.i_TX_Valid = 1'b1;
        while (!tx4.o_TX_Ready && stall < 2000) begin
            @(negedge clk);
            stall++;
        end
        if (!tx4.o_TX_Ready) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL send_timeout byte=%02h got ready=0 required ready=1", b);
        end else begin
            @(posedge clk);
            #1;
            sb_q.push_back(b);
            acc_cyc = cyc;
        end
    endtask

    task automatic drop_valid();
        @(negedge clk);
        tx4.i_TX_Valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks = checks + 1;
        if (done_cnt < target) begin
            errors = errors + 1;
            $display("FAIL wait_done got done_count=%0d required=%0d", done_cnt, target);
        end
    endtask

    task automatic check_int(input string name, input int got, input int req);
        checks = checks + 1;
        if (got != req) begin
            errors = errors + 1;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    logic [7:0] wrap_tab [12] = '{8'hC3, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E,
                                  8'h5A, 8'hA5, 8'h12, 8'hED, 8'h80, 8'h01};
    logic       ln87  [1000];
    logic       ac87  [1000];
    logic       dn87  [1000];

    initial begin : stim
        int stall;
        int base;
        int lows;
        int first_stall;
        int n;
        int pos;
        int len;
        int act_total;
        int done_idx;
        logic lvl;
        logic [7:0] rx;

        rst_n = 1'b0;
        tx4.i_TX_Byte   = 8'h00;
        tx4.i_TX_Valid  = 1'b0;
        tx87.i_TX_Byte  = 8'h00;
        tx87.i_TX_Valid = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check_int("rst_serial", int'(ser4), 1);
        check_int("rst_active", int'(act4), 0);
        check_int("rst_done",   int'(done4), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_int("rst_ready", int'(tx4.o_TX_Ready), 1);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!ser4 || act4) lows++;
        end
        check_int("rst_quiet_line", lows, 0);
        check_int("rst_no_done", done_cnt, 0);

        // Single byte 0xA5 with latency from accept to start bit
        base = done_cnt;
        start_q.delete();
        send_byte(8'hA5, stall);
        drop_valid();
        wait_done(base + 1, 200);
        check_int("single_start_seen", start_q.size(), 1);
        if (start_q.size() > 0) check_int("single_latency", start_q[0] - acc_cyc, 2);
        repeat (20) @(negedge clk);
        check_int("single_done_count", done_cnt, base + 1);

        // Full FIFO with Valid held: the sixth byte is the first to stall
        base = done_cnt;
        start_q.delete();
        first_stall = 0;
        for (int i = 1; i <= 6; i++) begin
            send_byte(8'(i), stall);
            if (stall > 0 && first_stall == 0) first_stall = i;
        end
        drop_valid();
        check_int("full_first_stall_byte", first_stall, 6);
        wait_done(base + 6, 1000);
        repeat (20) @(negedge clk);
        check_int("full_done_count", done_cnt, base + 6);
        check_int("full_frames", start_q.size(), 6);
        for (int i = 1; i < 6 && i < start_q.size(); i++)
            check_int("full_frame_spacing", start_q[i] - start_q[i-1], 10*c_CPB + 1);
        check_int("full_sb_empty", sb_q.size(), 0);

        // Wrap-around: four bursts of three
        for (int k = 0; k < 4; k++) begin
            base = done_cnt;
            for (int j = 0; j < 3; j++) send_byte(wrap_tab[3*k+j], stall);
            drop_valid();
            wait_done(base + 3, 600);
        end
        repeat (10) @(negedge clk);
        check_int("wrap_sb_empty", sb_q.size(), 0);
        check_int("wrap_ready", int'(tx4.o_TX_Ready), 1);

        // Reset during data bit 3 of 0x00 with two bytes queued behind it
        base = done_cnt;
        send_byte(8'h00, stall);
        send_byte(8'h11, stall);
        send_byte(8'h22, stall);
        drop_valid();
        n = 0;
        while (!act4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_int("midrst_frame_started", int'(act4), 1);
        repeat (4*c_CPB + 1) @(negedge clk);
        check_int("midrst_line_low", int'(ser4), 0);
        #1 rst_n = 1'b0;
        #1;
        check_int("midrst_async_serial", int'(ser4), 1);
        check_int("midrst_async_active", int'(act4), 0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!ser4 || act4) lows++;
        end
        check_int("midrst_no_resend", lows, 0);
        check_int("midrst_no_done", done_cnt, base);
        check_int("midrst_ready", int'(tx4.o_TX_Ready), 1);

        // Baud check at 87 clocks per bit with 0x55 (alternating levels)
        @(negedge clk);
        tx87.i_TX_Byte  = 8'h55;
        tx87.i_TX_Valid = 1'b1;
        @(negedge clk);
        tx87.i_TX_Valid = 1'b0;
        n = 0;
        while (ser87 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_int("baud_start_seen", int'(ser87), 0);
        for (int i = 0; i < 1000; i++) begin
            if (i != 0) @(negedge clk);
            ln87[i] = ser87;
            ac87[i] = act87;
            dn87[i] = done87;
        end
        pos = 0;
        for (int k = 0; k < 9; k++) begin
            lvl = ln87[pos];
            len = 0;
            while (pos < 1000 && ln87[pos] == lvl) begin
                pos++;
                len++;
            end
            check_int("baud_bit_width", len, c_CPB87);
        end
        act_total = 0;
        done_idx = -1;
        for (int i = 0; i < 1000; i++) begin
            if (ac87[i]) act_total++;
            if (dn87[i] && done_idx < 0) done_idx = i;
        end
        check_int("baud_frame_active", act_total, 10*c_CPB87);
        check_int("baud_done_index", done_idx, 10*c_CPB87);
        rx = 8'h00;
        for (int k = 0; k < 8; k++) rx[k] = ln87[c_CPB87*(k+1) + c_CPB87/2];
        check_int("baud_byte", int'(rx), 8'h55);
        check_int("baud_stop_high", int'(ln87[9*c_CPB87 + c_CPB87/2]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
